i3c_axi_sub_arb_mc: RTL and testbench

Multi-channel component-access arbiter: merges NCH independent simplex request channels (read or write sub-engines, possibly from several AXI ports) onto one component interface. Supersedes the fixed 2-port read/write arbiter. Adds the following over that arbiter:
- Selectable round-robin or fixed-priority policy.
- Burst locking.
- A C_LAT-deep return pipeline that routes read data and errors back to the issuing channel.

Sits between the AXI subordinate read/write engines and the register/SRAM component.

---
 rtl/i3c_axi_sub_arb_mc_pkg.sv | 22 ++
 rtl/i3c_axi_sub_arb_mc_if.sv | 69 ++++++
 rtl/i3c_axi_sub_arb_mc_rr_arb.sv | 34 +++
 rtl/i3c_axi_sub_arb_mc.sv | 113 +++++++++++
 tb/tb_i3c_axi_sub_arb_mc.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/i3c_axi_sub_arb_mc_pkg.sv
// Shared types for the multi-channel component-access arbiter.
// Arbitration policy, lock state and return-pipeline entry.
package i3ccore_axi_pkg;

    typedef enum logic {
        ARB_RR,
        ARB_FIXED
    } arb_mode_e;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_e;

    localparam int RET_IW = 8;

    typedef struct packed {
        logic              valid;
        logic [RET_IW-1:0] idx;
    } ret_t;

endpackage

// File: rtl/i3c_axi_sub_arb_mc_if.sv
// Channel-side and component-side bundles of the arbiter.
// master drives requests, slave answers them.
interface i3c_arb_ch_if #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int UW  = 32,
    parameter int IW  = 1
);
    localparam int BC = DW / 8;

    logic [NCH-1:0]         ch_dv;
    logic [NCH-1:0]         ch_write;
    logic [NCH-1:0][AW-1:0] ch_addr;
    logic [NCH-1:0][UW-1:0] ch_user;
    logic [NCH-1:0][IW-1:0] ch_id;
    logic [NCH-1:0][DW-1:0] ch_wdata;
    logic [NCH-1:0][BC-1:0] ch_wstrb;
    logic [NCH-1:0][2:0]    ch_size;
    logic [NCH-1:0]         ch_last;
    logic [NCH-1:0]         ch_hld;
    logic [NCH-1:0]         ch_wr_err;
    logic [NCH-1:0]         ch_rvalid;
    logic [NCH-1:0]         ch_rd_err;
    logic [DW-1:0]          ch_rdata;

    modport master (
        output ch_dv, ch_write, ch_addr, ch_user, ch_id,
        output ch_wdata, ch_wstrb, ch_size, ch_last,
        input  ch_hld, ch_wr_err, ch_rvalid, ch_rd_err, ch_rdata
    );
    modport slave (
        input  ch_dv, ch_write, ch_addr, ch_user, ch_id,
        input  ch_wdata, ch_wstrb, ch_size, ch_last,
        output ch_hld, ch_wr_err, ch_rvalid, ch_rd_err, ch_rdata
    );
endinterface

interface i3c_arb_comp_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int UW = 32,
    parameter int IW = 1
);
    localparam int BC = DW / 8;

    logic          dv;
    logic          write;
    logic [AW-1:0] addr;
    logic [UW-1:0] user;
    logic [IW-1:0] id;
    logic [DW-1:0] wdata;
    logic [BC-1:0] wstrb;
    logic [2:0]    size;
    logic          last;
    logic          hld;
    logic          rd_err;
    logic          wr_err;
    logic [DW-1:0] rdata;

    modport master (
        output dv, write, addr, user, id, wdata, wstrb, size, last,
        input  hld, rd_err, wr_err, rdata
    );
    modport slave (
        input  dv, write, addr, user, id, wdata, wstrb, size, last,
        output hld, rd_err, wr_err, rdata
    );
endinterface

// File: rtl/i3c_axi_sub_arb_mc_rr_arb.sv
// Combinational round-robin / fixed-priority picker.
// Lowest set bit of {req,req} masked below ptr gives the wrapped winner.
module i3c_rr_arb
    import i3ccore_axi_pkg::*;
#(
    parameter int        NCH       = 2,
    parameter arb_mode_e PRIO_MODE = ARB_RR,
    localparam int       CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  gnt_idx
);
    localparam int W2 = 2 * NCH;

    logic [CW-1:0] w_ptr;
    logic [W2-1:0] w_mask;
    logic [W2-1:0] w_sel;
    logic [W2-1:0] w_lo;

    assign w_ptr  = (PRIO_MODE == ARB_FIXED) ? '0 : ptr;
    assign w_mask = ~((W2'(1) << w_ptr) - W2'(1));
    assign w_sel  = {req, req} & w_mask;
    assign w_lo   = w_sel & (~w_sel + W2'(1));
    assign gnt    = w_lo[NCH-1:0] | w_lo[W2-1:NCH];

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt[i]) gnt_idx = gnt_idx | CW'(i);
        end
    end
endmodule

// File: rtl/i3c_axi_sub_arb_mc.sv
// Merges NCH request channels onto one component port with burst
// locking and a C_LAT-deep read-return routing pipeline.
module i3c_axi_sub_arb_mc
    import i3ccore_axi_pkg::*;
#(
    parameter int        AW        = 32,
    parameter int        DW        = 32,
    parameter int        UW        = 32,
    parameter int        IW        = 1,
    parameter int        NCH       = 2,
    parameter int        C_LAT     = 0,
    parameter arb_mode_e PRIO_MODE = ARB_RR,
    localparam int       CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    i3c_arb_ch_if.slave    ch,
    i3c_arb_comp_if.master cm,
    output logic [CW-1:0]  gnt_idx,
    output logic           locked
);
    lock_e          r_state;
    logic [CW-1:0]  r_lock_idx;
    logic [CW-1:0]  r_rr_ptr;
    logic [NCH-1:0] w_arb_gnt;
    logic [CW-1:0]  w_arb_idx;
    logic [CW-1:0]  w_g;
    logic [CW-1:0]  w_next;
    logic [NCH-1:0] w_oh;
    logic [NCH-1:0] w_rv;
    logic           w_locked;
    logic           w_last;
    logic           w_acc;
    logic           w_rd_acc;

    i3c_rr_arb #(
        .NCH      (NCH),
        .PRIO_MODE(PRIO_MODE)
    ) u_arb (
        .req    (ch.ch_dv),
        .ptr    (r_rr_ptr),
        .gnt    (w_arb_gnt),
        .gnt_idx(w_arb_idx)
    );

    assign w_locked = (r_state == LOCKED);
    assign w_g      = w_locked ? r_lock_idx : w_arb_idx;
    assign w_oh     = w_locked ? (NCH'(1) << r_lock_idx) : w_arb_gnt;
    assign w_last   = ch.ch_last[w_g];
    assign w_acc    = cm.dv && !cm.hld;
    assign w_rd_acc = w_acc && !cm.write;
    assign w_next   = (w_g == CW'(NCH - 1)) ? '0 : w_g + 1'b1;

    assign cm.dv    = w_locked ? ch.ch_dv[r_lock_idx] : |ch.ch_dv;
    assign cm.write = ch.ch_write[w_g];
    assign cm.addr  = ch.ch_addr[w_g];
    assign cm.user  = ch.ch_user[w_g];
    assign cm.id    = ch.ch_id[w_g];
    assign cm.wdata = ch.ch_wdata[w_g];
    assign cm.wstrb = ch.ch_wstrb[w_g];
    assign cm.size  = ch.ch_size[w_g];
    assign cm.last  = w_last;

    // Non-granted channels always see a stall.
    assign ch.ch_hld    = ~w_oh | {NCH{cm.hld}};
    assign ch.ch_wr_err = w_oh & {NCH{cm.wr_err && w_acc && cm.write}};
    assign ch.ch_rvalid = w_rv;
    assign ch.ch_rd_err = w_rv & {NCH{cm.rd_err}};
    assign ch.ch_rdata  = cm.rdata;

    assign gnt_idx = w_g;
    assign locked  = w_locked;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= UNLOCKED;
            r_lock_idx <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_acc && w_last) r_rr_ptr <= w_next;
            unique case (r_state)
                UNLOCKED: begin
                    if (w_acc && !w_last) begin
                        r_state    <= LOCKED;
                        r_lock_idx <= w_g;
                    end
                end
                LOCKED: begin
                    if (w_acc && w_last) r_state <= UNLOCKED;
                end
                default: r_state <= UNLOCKED;
            endcase
        end
    end

    if (C_LAT == 0) begin : g_lat0
        assign w_rv = w_rd_acc ? w_oh : '0;
    end else begin : g_pipe
        ret_t r_pipe [C_LAT];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < C_LAT; i++) r_pipe[i] <= '0;
            end else begin
                r_pipe[0] <= '{valid: w_rd_acc, idx: RET_IW'(w_g)};
                for (int i = 1; i < C_LAT; i++) r_pipe[i] <= r_pipe[i-1];
            end
        end

        assign w_rv = r_pipe[C_LAT-1].valid ?
                      (NCH'(1) << r_pipe[C_LAT-1].idx) : '0;
    end
endmodule

// File: tb/tb_i3c_axi_sub_arb_mc.sv
// Bench: NCH=3 round-robin at C_LAT=0 (table) and fixed-priority at
// C_LAT=2 (hand sequences, read returns checked through a scoreboard).
module tb_i3c_axi_sub_arb_mc;
    import i3ccore_axi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    i3c_arb_ch_if #(.NCH(3)) a_ch ();
    i3c_arb_comp_if          a_cm ();
    i3c_arb_ch_if #(.NCH(3)) b_ch ();
    i3c_arb_comp_if          b_cm ();
    logic [1:0] a_gnt, b_gnt;
    logic       a_lck, b_lck;

    i3c_axi_sub_arb_mc #(.NCH(3), .C_LAT(0), .PRIO_MODE(ARB_RR)) u_a (
        .clk(clk), .rst(rst), .ch(a_ch), .cm(a_cm),
        .gnt_idx(a_gnt), .locked(a_lck)
    );
    i3c_axi_sub_arb_mc #(.NCH(3), .C_LAT(2), .PRIO_MODE(ARB_FIXED)) u_b (
        .clk(clk), .rst(rst), .ch(b_ch), .cm(b_cm),
        .gnt_idx(b_gnt), .locked(b_lck)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        int   cyc;
        int   idx;
        logic err;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (|b_ch.ch_rvalid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL rv_spurious @cyc %0d: got %b want 000",
                         cyc, b_ch.ch_rvalid);
            end else begin
                e = sb.pop_front();
                chk("rv_cyc", 64'(cyc), 64'(e.cyc));
                chk("rv_idx", 64'(b_ch.ch_rvalid), 64'(1) << e.idx);
                chk("rv_err", 64'(b_ch.ch_rd_err),
                    e.err ? (64'(1) << e.idx) : 64'(0));
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            chk("rv_due", 64'(b_ch.ch_rvalid), 64'(1) << e.idx);
        end
    end

    typedef struct {
        logic [2:0] dv, wr, last;
        logic       hld, we;
        logic [1:0] gnt;
        logic       cdv;
        logic [2:0] chhld, rv, werr;
        logic       lck;
    } vec_t;

    task automatic b_drive(logic [2:0] dv, logic [2:0] last);
        b_ch.ch_dv    = dv;
        b_ch.ch_write = 3'b000;
        b_ch.ch_last  = last;
    endtask

    initial begin
        vec_t vt [17];
        //          dv      wr      last    h     we  | gnt  cdv  chhld  rv      werr    lck
        vt[0]  = '{3'b111, 3'b000, 3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b110, 3'b001, 3'b000, 1'b0};
        vt[1]  = '{3'b111, 3'b000, 3'b111, 1'b0, 1'b0, 2'd1, 1'b1, 3'b101, 3'b010, 3'b000, 1'b0};
        vt[2]  = '{3'b111, 3'b000, 3'b111, 1'b0, 1'b0, 2'd2, 1'b1, 3'b011, 3'b100, 3'b000, 1'b0};
        vt[3]  = '{3'b111, 3'b000, 3'b111, 1'b0, 1'b0, 2'd0, 1'b1, 3'b110, 3'b001, 3'b000, 1'b0};
        vt[4]  = '{3'b111, 3'b000, 3'b111, 1'b0, 1'b0, 2'd1, 1'b1, 3'b101, 3'b010, 3'b000, 1'b0};
        vt[5]  = '{3'b111, 3'b000, 3'b111, 1'b0, 1'b0, 2'd2, 1'b1, 3'b011, 3'b100, 3'b000, 1'b0};
        vt[6]  = '{3'b011, 3'b011, 3'b010, 1'b0, 1'b0, 2'd0, 1'b1, 3'b110, 3'b000, 3'b000, 1'b0};
        vt[7]  = '{3'b011, 3'b011, 3'b010, 1'b1, 1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 3'b000, 1'b1};
        vt[8]  = '{3'b011, 3'b011, 3'b010, 1'b1, 1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 3'b000, 1'b1};
        vt[9]  = '{3'b011, 3'b011, 3'b010, 1'b0, 1'b0, 2'd0, 1'b1, 3'b110, 3'b000, 3'b000, 1'b1};
        vt[10] = '{3'b011, 3'b011, 3'b010, 1'b0, 1'b0, 2'd0, 1'b1, 3'b110, 3'b000, 3'b000, 1'b1};
        vt[11] = '{3'b011, 3'b011, 3'b011, 1'b0, 1'b0, 2'd0, 1'b1, 3'b110, 3'b000, 3'b000, 1'b1};
        vt[12] = '{3'b010, 3'b010, 3'b010, 1'b0, 1'b0, 2'd1, 1'b1, 3'b101, 3'b000, 3'b000, 1'b0};
        vt[13] = '{3'b100, 3'b100, 3'b000, 1'b0, 1'b0, 2'd2, 1'b1, 3'b011, 3'b000, 3'b000, 1'b0};
        vt[14] = '{3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 2'd2, 1'b0, 3'b011, 3'b000, 3'b000, 1'b1};
        vt[15] = '{3'b101, 3'b101, 3'b100, 1'b0, 1'b1, 2'd2, 1'b1, 3'b011, 3'b000, 3'b100, 1'b1};
        vt[16] = '{3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 3'b000, 1'b0};

        for (int i = 0; i < 3; i++) begin
            a_ch.ch_addr[i]  = 32'h100 + 32'(16 * i);
            a_ch.ch_user[i]  = 32'(i);
            a_ch.ch_id[i]    = 1'(i);
            a_ch.ch_wdata[i] = 32'hA000 + 32'(i);
            a_ch.ch_wstrb[i] = 4'hF;
            a_ch.ch_size[i]  = 3'd2;
            b_ch.ch_addr[i]  = 32'h200 + 32'(16 * i);
            b_ch.ch_user[i]  = 32'(i);
            b_ch.ch_id[i]    = 1'(i);
            b_ch.ch_wdata[i] = 32'hB000 + 32'(i);
            b_ch.ch_wstrb[i] = 4'hF;
            b_ch.ch_size[i]  = 3'd2;
        end
        a_ch.ch_dv = '0; a_ch.ch_write = '0; a_ch.ch_last = '0;
        b_drive(3'b000, 3'b000);
        a_cm.hld = 0; a_cm.rd_err = 0; a_cm.wr_err = 0; a_cm.rdata = 32'h1234;
        b_cm.hld = 0; b_cm.rd_err = 0; b_cm.wr_err = 0; b_cm.rdata = 32'hCAFE0001;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_lck", 64'(a_lck), 0);
        chk("rst_a_gnt", 64'(a_gnt), 0);
        chk("rst_a_dv", 64'(a_cm.dv), 0);
        chk("rst_b_rv", 64'(b_ch.ch_rvalid), 0);
        chk("rst_b_lck", 64'(b_lck), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            a_ch.ch_dv    = vt[i].dv;
            a_ch.ch_write = vt[i].wr;
            a_ch.ch_last  = vt[i].last;
            a_cm.hld      = vt[i].hld;
            a_cm.wr_err   = vt[i].we;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), 64'(a_gnt), 64'(vt[i].gnt));
            chk($sformatf("v%0d_dv", i), 64'(a_cm.dv), 64'(vt[i].cdv));
            chk($sformatf("v%0d_chhld", i), 64'(a_ch.ch_hld), 64'(vt[i].chhld));
            chk($sformatf("v%0d_rv", i), 64'(a_ch.ch_rvalid), 64'(vt[i].rv));
            chk($sformatf("v%0d_werr", i), 64'(a_ch.ch_wr_err), 64'(vt[i].werr));
            chk($sformatf("v%0d_lck", i), 64'(a_lck), 64'(vt[i].lck));
            if (vt[i].cdv)
                chk($sformatf("v%0d_addr", i), 64'(a_cm.addr),
                    64'(32'h100 + 32'(16 * int'(vt[i].gnt))));
        end
        @(posedge clk); #1;
        a_ch.ch_dv = '0; a_cm.wr_err = 0;

        // Fixed priority: ch1 beats ch2 every cycle.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            b_drive(3'b110, 3'b111);
            sb.push_back('{cyc + 2, 1, 1'b0});
            @(negedge clk);
            chk("fx_gnt", 64'(b_gnt), 1);
            chk("fx_hld", 64'(b_ch.ch_hld), 64'(3'b101));
        end
        @(posedge clk); #1;
        b_drive(3'b000, 3'b111);
        repeat (3) @(posedge clk);

        // Back-to-back reads ch1 then ch0, error on the second return.
        #1;
        b_drive(3'b010, 3'b111);
        sb.push_back('{cyc + 2, 1, 1'b0});
        @(posedge clk); #1;
        b_drive(3'b001, 3'b111);
        sb.push_back('{cyc + 2, 0, 1'b1});
        @(posedge clk); #1;
        b_drive(3'b000, 3'b111);
        @(negedge clk);
        chk("rdata", 64'(b_ch.ch_rdata), 64'(32'hCAFE0001));
        @(posedge clk); #1;
        b_cm.rd_err = 1'b1;
        @(posedge clk); #1;
        b_cm.rd_err = 1'b0;
        repeat (2) @(posedge clk);

        // Reset mid-burst with reads in flight.
        #1;
        b_drive(3'b001, 3'b000);
        @(negedge clk);
        chk("mb_lck0", 64'(b_lck), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mb_lck1", 64'(b_lck), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        b_drive(3'b000, 3'b000);
        @(negedge clk);
        chk("mb_lck_after", 64'(b_lck), 0);
        chk("mb_gnt_after", 64'(b_gnt), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mb_no_rv", 64'(b_ch.ch_rvalid), 0);
        end

        repeat (2) @(posedge clk);
        chk("sb_empty", 64'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
